// File: rtl/jtdd_char_rom_if.sv
// jtdd_char_rom_if
// Bundles the character-ROM fetch signals between the video layer, the
// character ROM fetcher and the SDRAM arbiter port.
//   char_addr   byte address requested by video (held until rom_ok)
//   rom_data    ROM byte for char_addr
//   rom_ok      rom_data valid
//   sdram_req   SDRAM read request, level, held until acknowledged
//   sdram_addr  SDRAM 16-bit-word address
//   sdram_ack   one-cycle pulse: request accepted
//   data_rdy    one-cycle pulse: data_read valid
//   data_read   SDRAM read data
// Modports:
//   slave  - the fetcher (jtdd_char_rom)
//   master - the environment driving char_addr and the SDRAM responses
interface jtdd_char_rom_if;
  logic [14:0] char_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;

  modport slave (
    input  char_addr, sdram_ack, data_rdy, data_read,
    output rom_data, rom_ok, sdram_req, sdram_addr
  );

  modport master (
    output char_addr, sdram_ack, data_rdy, data_read,
    input  rom_data, rom_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_char_rom.sv
// jtdd_char_rom
// Character ROM fetcher with a one-line, 32-bit cache. Video presents a byte
// address; on a hit the byte is returned one cycle later, on a miss the
// containing 32-bit word is read from SDRAM and cached.
// Parameters:
//   CHAR_OFFSET  SDRAM word address of char ROM byte 0
//   TIMEOUT      cycles allowed per SDRAM phase (timeout build only)
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   downloading  ROM download in progress: blocks and invalidates the fetcher
//   bus          jtdd_char_rom_if.slave (video request/response + SDRAM port)
// Configuration macro:
//   JTDD_CHARROM_TIMEOUT_EN  abort a REQ/WAIT phase after TIMEOUT cycles
module jtdd_char_rom #(
  parameter logic [21:0] CHAR_OFFSET = 22'h0,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           downloading,
  jtdd_char_rom_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic        valid;
  logic [12:0] tag;
  logic [31:0] word;
  logic [12:0] fetch_tag;

  // Hit test and byte select look at the cache as it stands before the edge.
  logic        hit;
  logic [7:0]  sel_byte;

  assign hit      = valid && (tag == bus.char_addr[14:2]);
  assign sel_byte = word[{bus.char_addr[1:0], 3'b000} +: 8];

`ifdef JTDD_CHARROM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       expired;

  // Abort on the TIMEOUT-th cycle spent in the phase.
  assign expired = (cnt == TIMEOUT - 8'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= 1'b0;
      tag            <= '0;
      word           <= '0;
      fetch_tag      <= '0;
      bus.rom_data   <= 8'h00;
      bus.rom_ok     <= 1'b0;
      bus.sdram_req  <= 1'b0;
      bus.sdram_addr <= CHAR_OFFSET;
`ifdef JTDD_CHARROM_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else if (downloading) begin
      // Download owns the ROM: drop any fetch and forget the cached word.
      state         <= IDLE;
      valid         <= 1'b0;
      bus.rom_ok    <= 1'b0;
      bus.sdram_req <= 1'b0;
    end else begin
      bus.rom_ok   <= hit;
      bus.rom_data <= sel_byte;
`ifdef JTDD_CHARROM_TIMEOUT_EN
      cnt <= cnt + 8'd1;
`endif
      case (state)
        IDLE: begin
          if (!hit) begin
            fetch_tag      <= bus.char_addr[14:2];
            // 22-bit sum wraps modulo 2^22.
            bus.sdram_addr <= CHAR_OFFSET + {8'd0, bus.char_addr[14:2], 1'b0};
            bus.sdram_req  <= 1'b1;
            state          <= REQ;
`ifdef JTDD_CHARROM_TIMEOUT_EN
            cnt            <= '0;
`endif
          end
        end

        REQ: begin
          if (bus.sdram_ack) begin
            bus.sdram_req <= 1'b0;
            if (bus.data_rdy) begin
              word  <= bus.data_read;
              tag   <= fetch_tag;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WAIT;
`ifdef JTDD_CHARROM_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
`ifdef JTDD_CHARROM_TIMEOUT_EN
          end else if (expired) begin
            bus.sdram_req <= 1'b0;
            state         <= IDLE;
`endif
          end
        end

        WAIT: begin
          if (bus.data_rdy) begin
            word  <= bus.data_read;
            tag   <= fetch_tag;
            valid <= 1'b1;
            state <= IDLE;
`ifdef JTDD_CHARROM_TIMEOUT_EN
          end else if (expired) begin
            state <= IDLE;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_char_rom.sv
// tb_jtdd_char_rom
// Directed bench for jtdd_char_rom. A reference model (ROM contents as a
// function of word tag, plus the set of words the cache must hold) is checked
// against rom_ok/rom_data every cycle; directed steps pin SDRAM addresses,
// request timing and latencies with literal values.
module tb_jtdd_char_rom;
  localparam logic [21:0] OFF = 22'h3FF000;
`ifdef JTDD_CHARROM_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'd10;
`else
  localparam logic [7:0] TMO = 8'd255;
`endif

  logic clk = 1'b0;
  logic rst;
  logic downloading;
  jtdd_char_rom_if bus ();

  jtdd_char_rom #(.CHAR_OFFSET(OFF), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the cache: which word (if any) a completed fetch left behind.
  bit          m_valid = 1'b0;
  logic [12:0] m_tag   = '0;

  function automatic logic [31:0] rom_word(input logic [12:0] t);
    if (t == 13'd1) return 32'hDDCCBBAA;
    return ({19'd0, t} * 32'h0001_0003) ^ 32'h5AC3_96E1;
  endfunction

  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    logic [31:0] w;
    w = rom_word(a[14:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [12:0] t);
    m_valid = 1'b1;
    m_tag   = t;
  endtask

  // Complete a pending request with ack and data together.
  task automatic serve(input logic [12:0] t);
    bus.sdram_ack = 1'b1;
    bus.data_rdy  = 1'b1;
    bus.data_read = rom_word(t);
    step;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    fill(t);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    logic        p_rst, p_dl, e_ok;
    logic [14:0] p_addr;
    forever begin
      @(posedge clk);
      p_rst  = rst;
      p_dl   = downloading;
      p_addr = bus.char_addr;
      e_ok   = !p_rst && !p_dl && m_valid && (m_tag == p_addr[14:2]);
      #1;
      check("model_rom_ok", bus.rom_ok, e_ok);
      if (e_ok) check("model_rom_data", bus.rom_data, rom_byte(p_addr));
      if (p_rst || p_dl) check("model_req_blocked", bus.sdram_req, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hw;
    logic [21:0] a0;
    int n;

    rst = 1'b1;
    downloading   = 1'b0;
    bus.char_addr = 15'h0005;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = '0;
    step;
    step;
    check("rst_rom_ok", bus.rom_ok, 1'b0);
    check("rst_rom_data", bus.rom_data, 8'h00);
    check("rst_req", bus.sdram_req, 1'b0);
    check("rst_addr", bus.sdram_addr, OFF);

    // Reset then miss on 0005.
    rst = 1'b0;
    step;
    check("miss_req", bus.sdram_req, 1'b1);
    check("miss_addr", bus.sdram_addr, 22'h3FF002);
    step;
    step;
    check("miss_req_held", bus.sdram_req, 1'b1);
    bus.sdram_ack = 1'b1;
    step;
    bus.sdram_ack = 1'b0;
    check("miss_req_drop", bus.sdram_req, 1'b0);
    step;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hDDCCBBAA;
    step;
    bus.data_rdy  = 1'b0;
    fill(13'd1);
    check("miss_ok_early", bus.rom_ok, 1'b0);
    step;
    check("miss_ok", bus.rom_ok, 1'b1);
    check("miss_data", bus.rom_data, 8'hBB);

    // Hits across the cached word.
    hw = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      bus.char_addr = 15'h0004 + 15'(i);
      step;
      check("hit_ok", bus.rom_ok, 1'b1);
      check("hit_data", bus.rom_data, hw[8*i +: 8]);
      check("hit_noreq", bus.sdram_req, 1'b0);
    end

    // Same-cycle ack and data, top of the address space (offset wraps).
    bus.char_addr = 15'h7FFC;
    step;
    check("fast_req", bus.sdram_req, 1'b1);
    check("fast_addr", bus.sdram_addr, 22'h002FFE);
    serve(13'h1FFF);
    check("fast_ok_early", bus.rom_ok, 1'b0);
    check("fast_req_drop", bus.sdram_req, 1'b0);
    step;
    check("fast_ok", bus.rom_ok, 1'b1);
    check("fast_data", bus.rom_data, rom_byte(15'h7FFC));

    // Address change during WAIT.
    bus.char_addr = 15'h0010;
    step;
    check("mid_addr1", bus.sdram_addr, 22'h3FF008);
    bus.sdram_ack = 1'b1;
    step;
    bus.sdram_ack = 1'b0;
    bus.char_addr = 15'h0020;
    step;
    bus.data_rdy  = 1'b1;
    bus.data_read = rom_word(13'h4);
    step;
    bus.data_rdy  = 1'b0;
    fill(13'h4);
    check("mid_ok_after_fill", bus.rom_ok, 1'b0);
    step;
    check("mid_req2", bus.sdram_req, 1'b1);
    check("mid_addr2", bus.sdram_addr, 22'h3FF010);
    step;
    step;
    check("mid_ok_wait", bus.rom_ok, 1'b0);
    serve(13'h8);
    step;
    check("mid_ok", bus.rom_ok, 1'b1);

    // Download abort during WAIT, late data discarded.
    bus.char_addr = 15'h0040;
    step;
    check("dl_addr", bus.sdram_addr, 22'h3FF020);
    bus.sdram_ack = 1'b1;
    step;
    bus.sdram_ack = 1'b0;
    downloading = 1'b1;
    m_valid = 1'b0;
    step;
    check("dl_req", bus.sdram_req, 1'b0);
    check("dl_ok", bus.rom_ok, 1'b0);
    bus.data_rdy  = 1'b1;
    bus.data_read = rom_word(13'h10);
    step;
    bus.data_rdy  = 1'b0;
    step;
    bus.char_addr = 15'h0020;
    step;
    downloading = 1'b0;
    step;
    check("dl_fresh_req", bus.sdram_req, 1'b1);
    check("dl_fresh_addr", bus.sdram_addr, 22'h3FF010);
    serve(13'h8);
    step;
    check("dl_refill_ok", bus.rom_ok, 1'b1);
    bus.char_addr = 15'h0040;
    step;
    check("dl_no_stale_fill", bus.rom_ok, 1'b0);
    check("dl_retry_req", bus.sdram_req, 1'b1);
    serve(13'h10);
    step;

    // Reset mid-transaction; a later data_rdy lands while IDLE.
    bus.char_addr = 15'h0100;
    step;
    check("rm_addr", bus.sdram_addr, 22'h3FF080);
    rst = 1'b1;
    m_valid = 1'b0;
    step;
    rst = 1'b0;
    check("rm_req", bus.sdram_req, 1'b0);
    check("rm_addr_rst", bus.sdram_addr, OFF);
    bus.data_rdy  = 1'b1;
    bus.data_read = rom_word(13'h40);
    step;
    bus.data_rdy  = 1'b0;
    step;
    check("rm_ignored", bus.rom_ok, 1'b0);
    check("rm_req_again", bus.sdram_req, 1'b1);
    serve(13'h40);
    step;
    check("rm_ok", bus.rom_ok, 1'b1);

`ifdef JTDD_CHARROM_TIMEOUT_EN
    // No ack: request drops after TIMEOUT cycles and retries one cycle later.
    bus.char_addr = 15'h0080;
    step;
    a0 = bus.sdram_addr;
    check("tmo_addr", a0, 22'h3FF040);
    n = 0;
    while (bus.sdram_req && n < 40) begin
      step;
      n++;
    end
    check("tmo_len", n, 10);
    step;
    check("tmo_retry_req", bus.sdram_req, 1'b1);
    check("tmo_retry_addr", bus.sdram_addr, a0);
    serve(13'h20);
    step;
    check("tmo_ok", bus.rom_ok, 1'b1);
`else
    a0 = '0;
    n  = 0;
`endif

    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtdd_char_rom.md
# jtdd_char_rom

Responder side of the character ROM fetch interface used by `jtdd_video`. It accepts the byte address the character layer presents on `char_addr` and returns the ROM byte with a valid flag. It sources the data from SDRAM via the `sdram_req`/`sdram_ack`/`data_rdy` handshake and keeps the most recent 32-bit word in a one-line cache. It sits in `jtdd_game` between `u_video` and the SDRAM arbiter port.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h0, SDRAM 16-bit-word address of char ROM byte 0.
- `TIMEOUT`, 8'd255, cycles allowed per SDRAM transaction phase. Used only with the configuration macro.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `downloading`  in  1  ROM download in progress. Blocks and invalidates the fetcher.
- `char_addr`  in  15  byte address requested by video. Held stable by video until `rom_ok`.
- `rom_data`  out  8  ROM byte for `char_addr` sampled on the previous edge.
- `rom_ok`  out  1  `rom_data` is valid for that address.
- `sdram_req`  out  1  SDRAM read request. Level signal, held until acknowledged.
- `sdram_addr`  out  22  SDRAM word address.
- `sdram_ack`  in  1  one-cycle pulse: request accepted.
- `data_rdy`  in  1  one-cycle pulse: `data_read` is valid.
- `data_read`  in  32  SDRAM read data.

## Operation
- Cache line contents: `valid`, a 13-bit `tag` (char_addr[14:2]), and a 32-bit `word`.
- Hit condition: `valid && tag == char_addr[14:2]`.
- Byte select is little-endian: `rom_data = word[8*char_addr[1:0] +: 8]`.
- The FSM has three states: IDLE, REQ, WAIT.
- IDLE:
  - On a miss with `!downloading`: latch `fetch_tag = char_addr[14:2]`, set `sdram_addr = CHAR_OFFSET + {fetch_tag,1'b0}`, go to REQ.
  - On a hit, stay in IDLE.
- REQ:
  - `sdram_req = 1`.
  - `sdram_ack` alone → WAIT.
  - `sdram_ack && data_rdy` in the same cycle → capture the data (same action as WAIT), go to IDLE.
  - `data_rdy` without `sdram_ack` is ignored.
- WAIT:
  - On `data_rdy`: `word <= data_read`, `tag <= fetch_tag`, `valid <= 1`, go to IDLE.
  - `sdram_ack` is ignored.
- If `char_addr` changes during REQ or WAIT, the current fetch still completes and fills the cache. The hit test is then redone in IDLE, and a new miss starts a new fetch.
- Asserting `downloading` in any state:
  - go to IDLE, drop `sdram_req`, clear `valid`, force `rom_ok = 0`.
  - A `data_rdy` arriving during download is discarded.
- The cache is written only from a completed fetch. `sdram_addr` is stable from entry to REQ until the next IDLE→REQ transition.
- Width rule: the sum `CHAR_OFFSET + {tag,1'b0}` is 22 bits and wraps modulo 2^22.

## Timing
- Reset values:
  - state = IDLE
  - `valid = 0`, `tag = 0`, `word = 0`
  - `rom_data = 8'h00`, `rom_ok = 0`
  - `sdram_req = 0`, `sdram_addr = CHAR_OFFSET`
- Reset applied mid-transaction is taken on the next edge. A later `data_rdy` for the aborted request is ignored, because the FSM is in IDLE.
- Outputs are registered:
  - `rom_ok` and `rom_data` at edge t reflect the hit test on `char_addr` and the cache contents before edge t.
  - Hit latency is 1 cycle.
- Miss timeline (miss address present before edge 0):
  - `sdram_req` high after edge 0.
  - Ack sampled at edge k → `sdram_req` low after edge k.
  - `data_rdy` sampled at edge n → cache valid after edge n.
  - `rom_ok` high after edge n+1.
- Minimum miss-to-`rom_ok` (ack and `data_rdy` in the same cycle at edge 1): `rom_ok` high after edge 2. That is 3 cycles.
- After a fill there is at most one IDLE cycle before the next request.

## Configuration
- `JTDD_CHARROM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and on entry to WAIT, and increments every cycle in those states.
  - When it reaches `TIMEOUT` without the awaited `sdram_ack`/`data_rdy`, the FSM aborts to IDLE, drops `sdram_req`, and leaves the cache unchanged.
  - A still-missing address then retries from IDLE on the next cycle.
- Undefined: no counter. REQ and WAIT wait indefinitely.

## Test plan
- Reset then miss:
  - Stimulus: reset, then `char_addr=15'h0005`; ack 3 cycles after `sdram_req`; `data_rdy` 2 cycles later with `data_read=32'hDDCCBBAA`.
  - Required: `sdram_addr=CHAR_OFFSET+22'h2`; `rom_data=8'hBB`, `rom_ok=1` 2 cycles after `data_rdy`.
- Hit:
  - Stimulus: after the previous fill, `char_addr` steps 0004→0007.
  - Required: `rom_data` = AA, BB, CC, DD on successive cycles, `rom_ok` held 1, no `sdram_req`.
- Same-cycle ack and data:
  - Stimulus: miss on `15'h7FFC` with `sdram_ack` and `data_rdy` together on the first request cycle.
  - Required: `sdram_addr=CHAR_OFFSET+22'h3FFE`; `rom_ok=1` 3 cycles after the miss address was presented.
- Address change mid-fetch:
  - Stimulus: miss on 0010, switch to 0020 during WAIT.
  - Required: 0010 fill completes; a second request with `sdram_addr` offset `22'h10` follows; `rom_ok` stays 0 until the 0020 data arrives.
- Download abort:
  - Stimulus: `downloading=1` during WAIT, `data_rdy` arrives during the download.
  - Required: `sdram_req=0`, `rom_ok=0`, cache invalid; the first access after `downloading=0` issues a fresh request.
- Timeout (macro defined, `TIMEOUT=8'd10`):
  - Stimulus: never assert `sdram_ack`.
  - Required: `sdram_req` drops after 10 cycles, then reasserts the same `sdram_addr` 1 cycle later.
